// File: rtl/axi_grid_xy_fork.sv
// axi_grid_xy_fork: per-node ingress stage of the AXI grid fabric.
// Buffers one flit stream in a 2-entry FIFO and routes each flit X-first to
// the horizontal, vertical or local output. The route is decided at enqueue
// and stored with the entry, so the output side is a simple valid demux.
// Optional feature macro: AXI_GRID_FORK_ERR_EN (out-of-grid drop + err_cnt_o).
module axi_grid_xy_fork #(
  parameter type         grid_id_t = logic [7:0],
  parameter type         chan_t    = logic [7:0],
  parameter int unsigned NODE_X    = 0,
  parameter int unsigned NODE_Y    = 0,
  parameter int unsigned GRID_X    = 4,
  parameter int unsigned GRID_Y    = 4,
  localparam int         W         = $bits(grid_id_t),
  localparam int         CW        = $bits(chan_t)
) (
  input  logic          clk_i,
  input  logic          arst_ni,
  input  logic [W-1:0]  did_i,
  input  logic [W-1:0]  sid_i,
  input  logic [CW-1:0] chan_i,
  input  logic          valid_i,
  output logic          ready_o,
  output logic [W-1:0]  h_did_o,
  output logic [W-1:0]  h_sid_o,
  output logic [CW-1:0] h_chan_o,
  output logic          h_valid_o,
  input  logic          h_ready_i,
  output logic [W-1:0]  v_did_o,
  output logic [W-1:0]  v_sid_o,
  output logic [CW-1:0] v_chan_o,
  output logic          v_valid_o,
  input  logic          v_ready_i,
  output logic [W-1:0]  l_did_o,
  output logic [W-1:0]  l_sid_o,
  output logic [CW-1:0] l_chan_o,
  output logic          l_valid_o,
`ifdef AXI_GRID_FORK_ERR_EN
  output logic [7:0]    err_cnt_o,
`endif
  input  logic          l_ready_i
);

  localparam int HW = W / 2;
  localparam logic [HW-1:0] NODE_X_C = HW'(NODE_X);
  localparam logic [HW-1:0] NODE_Y_C = HW'(NODE_Y);

  // An odd ID width or an empty grid cannot describe a valid fabric node.
  if ((W % 2) != 0 || GRID_X == 0 || GRID_Y == 0) begin : g_bad_config
    $error("axi_grid_xy_fork: ID width must be even and grid non-empty");
  end

  typedef enum logic [1:0] {
    ROUTE_H = 2'd0,
    ROUTE_V = 2'd1,
    ROUTE_L = 2'd2
  } route_e;

  logic [W-1:0]  did_q   [2];
  logic [W-1:0]  did_d   [2];
  logic [W-1:0]  sid_q   [2];
  logic [W-1:0]  sid_d   [2];
  logic [CW-1:0] chan_q  [2];
  logic [CW-1:0] chan_d  [2];
  route_e        route_q [2];
  route_e        route_d [2];
  logic          wr_ptr_q, wr_ptr_d;
  logic          rd_ptr_q, rd_ptr_d;
  logic [1:0]    count_q, count_d;

  logic [HW-1:0] in_x;
  logic [HW-1:0] in_y;
  route_e        in_route;
  route_e        head_route;
  logic          head_vld;
  logic          accept;
  logic          enq;
  logic          deq;

  // X-first routing decision for the incoming flit.
  always_comb begin
    in_x     = did_i[HW-1:0];
    in_y     = did_i[W-1:HW];
    in_route = ROUTE_L;
    if (in_x != NODE_X_C) begin
      in_route = ROUTE_H;
    end else if (in_y != NODE_Y_C) begin
      in_route = ROUTE_V;
    end
  end

  // Input handshake depends only on the registered fill level.
  assign ready_o = (count_q != 2'd2);
  assign accept  = valid_i && ready_o;

`ifdef AXI_GRID_FORK_ERR_EN
  logic       in_legal;
  logic [7:0] err_cnt_q, err_cnt_d;

  // Out-of-grid destinations are swallowed instead of being stored.
  always_comb begin
    in_legal  = (32'(in_x) < GRID_X) && (32'(in_y) < GRID_Y);
    err_cnt_d = err_cnt_q;
    if (accept && !in_legal && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  assign enq       = accept && in_legal;
  assign err_cnt_o = err_cnt_q;

  // Drop counter register, saturating at its maximum.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      err_cnt_q <= 8'd0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end
`else
  assign enq = accept;
`endif

  // Head entry drives every port's data; only the routed port sees valid.
  always_comb begin
    head_vld   = (count_q != 2'd0);
    head_route = route_q[rd_ptr_q];
    h_valid_o  = head_vld && (head_route == ROUTE_H);
    v_valid_o  = head_vld && (head_route == ROUTE_V);
    l_valid_o  = head_vld && (head_route == ROUTE_L);
    h_did_o    = did_q[rd_ptr_q];
    v_did_o    = did_q[rd_ptr_q];
    l_did_o    = did_q[rd_ptr_q];
    h_sid_o    = sid_q[rd_ptr_q];
    v_sid_o    = sid_q[rd_ptr_q];
    l_sid_o    = sid_q[rd_ptr_q];
    h_chan_o   = chan_q[rd_ptr_q];
    v_chan_o   = chan_q[rd_ptr_q];
    l_chan_o   = chan_q[rd_ptr_q];
    deq        = (h_valid_o && h_ready_i) ||
                 (v_valid_o && v_ready_i) ||
                 (l_valid_o && l_ready_i);
  end

  // FIFO next state: write at wr_ptr on enqueue, advance rd_ptr on dequeue.
  always_comb begin
    did_d    = did_q;
    sid_d    = sid_q;
    chan_d   = chan_q;
    route_d  = route_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (enq) begin
      did_d[wr_ptr_q]   = did_i;
      sid_d[wr_ptr_q]   = sid_i;
      chan_d[wr_ptr_q]  = chan_i;
      route_d[wr_ptr_q] = in_route;
      wr_ptr_d          = ~wr_ptr_q;
    end
    if (deq) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({enq, deq})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // FIFO state register; reset discards any buffered flits.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      for (int i = 0; i < 2; i++) begin
        did_q[i]   <= '0;
        sid_q[i]   <= '0;
        chan_q[i]  <= '0;
        route_q[i] <= ROUTE_H;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      did_q    <= did_d;
      sid_q    <= sid_d;
      chan_q   <= chan_d;
      route_q  <= route_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_axi_grid_xy_fork.sv
// tb_axi_grid_xy_fork: directed bench for axi_grid_xy_fork with NODE=(1,1)
// on a 4x4 grid. A scoreboard queue mirrors the FIFO contents; the negedge
// monitor compares ready/valid/data against its head every cycle.
// Define AXI_GRID_FORK_ERR_EN to exercise the drop counter.
module tb_axi_grid_xy_fork;

  logic       clk_i = 1'b0;
  logic       arst_ni;
  logic [7:0] did_i, sid_i, chan_i;
  logic       valid_i;
  logic       ready_o;
  logic [7:0] h_did_o, h_sid_o, h_chan_o;
  logic       h_valid_o, h_ready_i;
  logic [7:0] v_did_o, v_sid_o, v_chan_o;
  logic       v_valid_o, v_ready_i;
  logic [7:0] l_did_o, l_sid_o, l_chan_o;
  logic       l_valid_o, l_ready_i;
`ifdef AXI_GRID_FORK_ERR_EN
  logic [7:0] err_cnt_o;
`endif

  axi_grid_xy_fork #(
    .NODE_X(1), .NODE_Y(1), .GRID_X(4), .GRID_Y(4)
  ) dut (
    .clk_i(clk_i), .arst_ni(arst_ni),
    .did_i(did_i), .sid_i(sid_i), .chan_i(chan_i),
    .valid_i(valid_i), .ready_o(ready_o),
    .h_did_o(h_did_o), .h_sid_o(h_sid_o), .h_chan_o(h_chan_o),
    .h_valid_o(h_valid_o), .h_ready_i(h_ready_i),
    .v_did_o(v_did_o), .v_sid_o(v_sid_o), .v_chan_o(v_chan_o),
    .v_valid_o(v_valid_o), .v_ready_i(v_ready_i),
    .l_did_o(l_did_o), .l_sid_o(l_sid_o), .l_chan_o(l_chan_o),
    .l_valid_o(l_valid_o),
`ifdef AXI_GRID_FORK_ERR_EN
    .err_cnt_o(err_cnt_o),
`endif
    .l_ready_i(l_ready_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [7:0] did;
    logic [7:0] sid;
    logic [7:0] chan;
    logic [1:0] port;
  } flit_t;

  flit_t sb[$];
  int    compared   = 0;
  int    mismatched = 0;
  int    err_model  = 0;
  int    cycle      = 0;
  bit    rand_ready = 1'b0;
  flit_t mon_head;
  bit    mon_have;
  bit    mon_room;
  bit    mon_take;

  always @(posedge clk_i) cycle++;

  // Expected port: 0 = horizontal, 1 = vertical, 2 = local (node is (1,1)).
  function automatic logic [1:0] expectPort(input logic [7:0] did);
    if (did[3:0] != 4'd1) return 2'd0;
    if (did[7:4] != 4'd1) return 2'd1;
    return 2'd2;
  endfunction

  function automatic bit inGrid(input logic [7:0] did);
    return (did[3:0] < 4'd4) && (did[7:4] < 4'd4);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Per-cycle monitor: compare against the model head, then pop and push.
  always @(negedge clk_i) begin
    if (arst_ni === 1'b1) begin
      mon_have = (sb.size() != 0);
      mon_room = (sb.size() != 2);
      mon_head = mon_have ? sb[0] : '0;
      checkOutput("ready_o", ready_o, mon_room);
      checkOutput("h_valid_o", h_valid_o, mon_have && mon_head.port == 2'd0);
      checkOutput("v_valid_o", v_valid_o, mon_have && mon_head.port == 2'd1);
      checkOutput("l_valid_o", l_valid_o, mon_have && mon_head.port == 2'd2);
`ifdef AXI_GRID_FORK_ERR_EN
      checkOutput("err_cnt_o", err_cnt_o, err_model);
`endif
      if (mon_have) begin
        checkOutput("h_did_o", h_did_o, mon_head.did);
        checkOutput("v_did_o", v_did_o, mon_head.did);
        checkOutput("l_did_o", l_did_o, mon_head.did);
        checkOutput("h_sid_o", h_sid_o, mon_head.sid);
        checkOutput("v_sid_o", v_sid_o, mon_head.sid);
        checkOutput("l_sid_o", l_sid_o, mon_head.sid);
        checkOutput("h_chan_o", h_chan_o, mon_head.chan);
        checkOutput("v_chan_o", v_chan_o, mon_head.chan);
        checkOutput("l_chan_o", l_chan_o, mon_head.chan);
        mon_take = (mon_head.port == 2'd0 && h_ready_i) ||
                   (mon_head.port == 2'd1 && v_ready_i) ||
                   (mon_head.port == 2'd2 && l_ready_i);
        if (mon_take) void'(sb.pop_front());
      end
      if (valid_i && mon_room) begin
`ifdef AXI_GRID_FORK_ERR_EN
        if (!inGrid(did_i)) begin
          if (err_model < 255) err_model++;
        end else begin
          sb.push_back('{did_i, sid_i, chan_i, expectPort(did_i)});
        end
`else
        sb.push_back('{did_i, sid_i, chan_i, expectPort(did_i)});
`endif
      end
    end
  end

  task automatic syncEdge();
    @(posedge clk_i);
    #1;
  endtask

  task automatic driveFlit(input logic [7:0] did, input logic [7:0] sid,
                           input logic [7:0] chan);
    did_i   = did;
    sid_i   = sid;
    chan_i  = chan;
    valid_i = 1'b1;
  endtask

  // Hold valid until the handshake completes or the budget runs out.
  task automatic waitAccept(input int budget);
    bit done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk_i);
      done = ready_o;
      @(posedge clk_i);
      #1;
      if (rand_ready) begin
        h_ready_i = 1'($urandom_range(0, 1));
        v_ready_i = 1'($urandom_range(0, 1));
        l_ready_i = 1'($urandom_range(0, 1));
      end
    end
    valid_i = 1'b0;
    if (!done) checkOutput("accept_timeout", 0, 1);
  endtask

  task automatic applyStimulus(input logic [7:0] did, input logic [7:0] sid,
                               input logic [7:0] chan);
    driveFlit(did, sid, chan);
    waitAccept(50);
  endtask

  task automatic waitDrain(input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) syncEdge();
    if (sb.size() != 0) checkOutput("drain_timeout", sb.size(), 0);
  endtask

  initial begin
    int start;
    arst_ni   = 1'b0;
    valid_i   = 1'b0;
    did_i     = '0;
    sid_i     = '0;
    chan_i    = '0;
    h_ready_i = 1'b1;
    v_ready_i = 1'b1;
    l_ready_i = 1'b1;
    #3;
    checkOutput("rst_ready_o", ready_o, 1);
    checkOutput("rst_h_valid", h_valid_o, 0);
    checkOutput("rst_v_valid", v_valid_o, 0);
    checkOutput("rst_l_valid", l_valid_o, 0);
`ifdef AXI_GRID_FORK_ERR_EN
    checkOutput("rst_err_cnt", err_cnt_o, 0);
`endif
    repeat (2) @(posedge clk_i);
    #1 arst_ni = 1'b1;
    syncEdge();

    $display("[TB] single flit to H, one-cycle latency");
    applyStimulus(8'h13, 8'hA1, 8'h5C);
    @(negedge clk_i);
    checkOutput("lat_h_valid", h_valid_o, 1);
    checkOutput("lat_v_valid", v_valid_o, 0);
    checkOutput("lat_l_valid", l_valid_o, 0);
    checkOutput("lat_h_did", h_did_o, 8'h13);
    checkOutput("lat_h_sid", h_sid_o, 8'hA1);
    checkOutput("lat_h_chan", h_chan_o, 8'h5C);
    @(negedge clk_i);
    checkOutput("empty_h_valid", h_valid_o, 0);
    syncEdge();

    $display("[TB] back-to-back V then L");
    applyStimulus(8'h21, 8'hB2, 8'h11);
    driveFlit(8'h11, 8'hB3, 8'h22);
    @(negedge clk_i);
    checkOutput("b2b_v_valid", v_valid_o, 1);
    checkOutput("b2b_ready", ready_o, 1);
    @(posedge clk_i);
    #1 valid_i = 1'b0;
    @(negedge clk_i);
    checkOutput("b2b_l_valid", l_valid_o, 1);
    checkOutput("b2b_v_clear", v_valid_o, 0);
    syncEdge();
    waitDrain(10);

    $display("[TB] full FIFO with H stalled");
    h_ready_i = 1'b0;
    applyStimulus(8'h30, 8'h01, 8'hC1);
    applyStimulus(8'h31, 8'h02, 8'hC2);
    driveFlit(8'h32, 8'h03, 8'hC3);
    repeat (3) begin
      @(negedge clk_i);
      checkOutput("full_ready_o", ready_o, 0);
      syncEdge();
    end
    h_ready_i = 1'b1;
    @(negedge clk_i);
    checkOutput("ready_no_comb", ready_o, 0);
    waitAccept(10);
    waitDrain(10);

    $display("[TB] head-of-line blocking V before L");
    v_ready_i = 1'b0;
    applyStimulus(8'h21, 8'h04, 8'hD1);
    applyStimulus(8'h11, 8'h05, 8'hD2);
    repeat (3) begin
      @(negedge clk_i);
      checkOutput("hol_l_valid", l_valid_o, 0);
      checkOutput("hol_v_valid", v_valid_o, 1);
      syncEdge();
    end
    v_ready_i = 1'b1;
    waitDrain(10);

    $display("[TB] sustained throughput to L");
    start = cycle;
    for (int i = 0; i < 8; i++) applyStimulus(8'h11, 8'(i), 8'(8'h40 + i));
    checkOutput("throughput_cycles", cycle - start, 8);
    waitDrain(10);

    $display("[TB] async reset while full");
    h_ready_i = 1'b0;
    applyStimulus(8'h30, 8'h06, 8'hE1);
    applyStimulus(8'h32, 8'h07, 8'hE2);
    @(negedge clk_i);
    checkOutput("pre_rst_ready", ready_o, 0);
    #2 arst_ni = 1'b0;
    sb.delete();
    #1;
    checkOutput("mid_rst_ready", ready_o, 1);
    checkOutput("mid_rst_h_valid", h_valid_o, 0);
    checkOutput("mid_rst_v_valid", v_valid_o, 0);
    checkOutput("mid_rst_l_valid", l_valid_o, 0);
    syncEdge();
    arst_ni   = 1'b0;
    syncEdge();
    arst_ni   = 1'b1;
    h_ready_i = 1'b1;
    repeat (3) begin
      @(negedge clk_i);
      checkOutput("stale_h_valid", h_valid_o, 0);
    end
    syncEdge();

    $display("[TB] out-of-grid destination");
    applyStimulus(8'h15, 8'h08, 8'hF1);
    @(negedge clk_i);
`ifdef AXI_GRID_FORK_ERR_EN
    checkOutput("oog_h_valid", h_valid_o, 0);
    checkOutput("oog_err_cnt", err_cnt_o, 1);
    syncEdge();
    for (int i = 0; i < 299; i++)
      applyStimulus((i % 2 == 0) ? 8'h15 : 8'h41, 8'h09, 8'(i));
    @(negedge clk_i);
    checkOutput("err_cnt_sat", err_cnt_o, 255);
    syncEdge();
`else
    checkOutput("oog_h_valid", h_valid_o, 1);
    syncEdge();
    waitDrain(10);
`endif

    $display("[TB] random stream with random readys");
    rand_ready = 1'b1;
    for (int i = 0; i < 24; i++)
      applyStimulus({4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))},
                    8'($urandom), 8'($urandom));
    rand_ready = 1'b0;
    h_ready_i  = 1'b1;
    v_ready_i  = 1'b1;
    l_ready_i  = 1'b1;
    waitDrain(20);
    @(negedge clk_i);
    checkOutput("final_ready", ready_o, 1);
    syncEdge();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
